// File: rtl/calc_pkg.sv
// Shared calculator constants: FSM state encoding, double-dabble adjust constants
// and the multiplier product width.
package calc_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ        = 4'd3;

   localparam int PRODUCT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      LOAD  = ST_LOAD,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/signed_product_to_bcd_if.sv
// Product-in / BCD-out bundle between the multiplier and the display converter.
// The blank vector exists only when SIGNED_PRODUCT_TO_BCD_BLANK_EN is defined.
import calc_pkg::*;

interface signed_product_to_bcd_if #(
   parameter int WIDTH  = PRODUCT_W,
   parameter int DIGITS = 3
);
   logic signed [WIDTH-1:0]    product;
   logic                       start;
   logic                       sign;
   logic        [4*DIGITS-1:0] bcd;
   logic                       busy;
   logic                       done;
`ifdef SIGNED_PRODUCT_TO_BCD_BLANK_EN
   logic        [DIGITS-1:0]   blank;
`endif

   modport master (
      output product, start,
`ifdef SIGNED_PRODUCT_TO_BCD_BLANK_EN
      input  blank,
`endif
      input  sign, bcd, busy, done
   );

   modport slave (
      input  product, start,
`ifdef SIGNED_PRODUCT_TO_BCD_BLANK_EN
      output blank,
`endif
      output sign, bcd, busy, done
   );
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: a digit of 5 or more gets 3 added before the shift.
import calc_pkg::*;

module bcd_digit_adjust (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ : din;
endmodule

// File: rtl/signed_product_to_bcd.sv
// Converts a two's-complement product to sign + BCD digits, one double-dabble bit per clock.
// Optional leading-zero blank output enabled by SIGNED_PRODUCT_TO_BCD_BLANK_EN.
import calc_pkg::*;

module signed_product_to_bcd #(
   parameter int WIDTH  = PRODUCT_W,
   parameter int DIGITS = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   signed_product_to_bcd_if.slave    bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t                   state, state_nxt;
   logic signed [WIDTH-1:0]  operand;
   logic        [WIDTH-1:0]  mag;
   logic                     neg;
   logic        [BCD_W-1:0]  scratch, scratch_adj;
   logic        [CNT_W-1:0]  cnt;
   logic        [BCD_W+WIDTH-1:0] shifted;
   logic                     sign_q;
   logic        [BCD_W-1:0]  bcd_q;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adjust u_adj (
         .din  (scratch[4*i +: 4]),
         .dout (scratch_adj[4*i +: 4])
      );
   end

   assign shifted = {scratch_adj, mag} << 1;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (cnt == LAST_BIT) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef SIGNED_PRODUCT_TO_BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q;

   // Digit i is blank when it and every more significant digit are zero; units never blank.
   function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] b);
      logic [DIGITS-1:0] r;
      logic              zero;
      r = '0;
      for (int i = 1; i < DIGITS; i++) begin
         zero = 1'b1;
         for (int j = i; j < DIGITS; j++)
            if (b[4*j +: 4] != 4'd0) zero = 1'b0;
         r[i] = zero;
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst)
         blank_q <= '0;
      else if (state == SHIFT && cnt == LAST_BIT)
         blank_q <= blank_of(shifted[BCD_W+WIDTH-1:WIDTH]);
   end

   assign bus.blank = blank_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         operand <= '0;
         mag     <= '0;
         neg     <= 1'b0;
         scratch <= '0;
         cnt     <= '0;
         sign_q  <= 1'b0;
         bcd_q   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) operand <= bus.product;
            LOAD: begin
               // -2^(WIDTH-1) negates to itself; read unsigned it is the correct magnitude.
               mag     <= operand[WIDTH-1] ? (~operand + 1'b1) : operand;
               neg     <= operand[WIDTH-1];
               scratch <= '0;
               cnt     <= '0;
            end
            SHIFT: begin
               scratch <= shifted[BCD_W+WIDTH-1:WIDTH];
               mag     <= shifted[WIDTH-1:0];
               cnt     <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  sign_q <= neg;
                  bcd_q  <= shifted[BCD_W+WIDTH-1:WIDTH];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sign = sign_q;
   assign bus.bcd  = bcd_q;
   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);

endmodule
